// File: rtl/operand_loader.sv
// Operand entry front end: four switch captures, one per filtered key press.
// Optional rerun from FINISHED is enabled by defining LOADER_RERUN_EN.
module operand_loader #(
  parameter int WIDTH       = 16,
  parameter int HOLD_CYCLES = 1000
) (
  input  logic             CLOCK_50,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_data,
  input  logic             key_n,
  input  logic             done,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             start,
  output logic [2:0]       stage,
  output logic             dut_rst_n
);

  typedef enum logic [3:0] {
    S_PA   = 4'd0,
    S_PB   = 4'd1,
    S_PC   = 4'd2,
    S_PD   = 4'd3,
    S_RA   = 4'd4,
    S_RB   = 4'd5,
    S_RC   = 4'd6,
    S_RD   = 4'd7,
    S_RUN  = 4'd8,
    S_FIN  = 4'd9,
    S_FREL = 4'd10
  } state_t;

  localparam logic [19:0] KMAX = 20'(HOLD_CYCLES - 1);

  state_t      state;
  logic [19:0] kcnt;
  logic        press_wait;
  logic        rel_wait;
  logic        hit;
  logic        qual;

  // Which key level the current state is waiting for.
  always_comb begin
    press_wait = 1'b0;
    rel_wait   = 1'b0;
    unique case (state)
      S_PA, S_PB, S_PC, S_PD: press_wait = 1'b1;
      S_RA, S_RB, S_RC, S_RD: rel_wait = 1'b1;
`ifdef LOADER_RERUN_EN
      S_FIN:  press_wait = 1'b1;
      S_FREL: rel_wait = 1'b1;
`endif
      default: ;
    endcase
    hit  = (press_wait && !key_n) || (rel_wait && key_n);
    qual = hit && (kcnt == KMAX);
  end

`ifdef LOADER_RERUN_EN
  logic [1:0] rlow;

  // Entry FSM with key filter, operand capture and rerun soft reset.
  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      state     <= S_PA;
      kcnt      <= '0;
      a         <= '0;
      b         <= '0;
      c         <= '0;
      d         <= '0;
      start     <= 1'b0;
      stage     <= 3'd0;
      dut_rst_n <= 1'b1;
      rlow      <= 2'd0;
    end else begin
      kcnt <= (hit && !qual) ? kcnt + 20'd1 : 20'd0;
      if (rlow != 2'd0) begin
        rlow      <= rlow - 2'd1;
        dut_rst_n <= (rlow == 2'd1);
      end
      unique case (state)
        S_PA: if (qual) begin a <= sw_data; state <= S_RA; end
        S_PB: if (qual) begin b <= sw_data; state <= S_RB; end
        S_PC: if (qual) begin c <= sw_data; state <= S_RC; end
        S_PD: if (qual) begin d <= sw_data; state <= S_RD; end
        S_RA: if (qual) begin state <= S_PB; stage <= 3'd1; end
        S_RB: if (qual) begin state <= S_PC; stage <= 3'd2; end
        S_RC: if (qual) begin state <= S_PD; stage <= 3'd3; end
        S_RD: if (qual) begin
          state <= S_RUN;
          stage <= 3'd4;
          start <= 1'b1;
        end
        S_RUN: if (done) begin state <= S_FIN; stage <= 3'd5; end
        S_FIN: if (qual) state <= S_FREL;
        S_FREL: if (qual) begin
          state     <= S_PA;
          stage     <= 3'd0;
          start     <= 1'b0;
          dut_rst_n <= 1'b0;
          rlow      <= 2'd2;
        end
        default: begin
          state <= S_PA;
          stage <= 3'd0;
          start <= 1'b0;
        end
      endcase
    end
  end
`else
  assign dut_rst_n = 1'b1;

  // Entry FSM with key filter and operand capture; FINISHED is terminal.
  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      state <= S_PA;
      kcnt  <= '0;
      a     <= '0;
      b     <= '0;
      c     <= '0;
      d     <= '0;
      start <= 1'b0;
      stage <= 3'd0;
    end else begin
      kcnt <= (hit && !qual) ? kcnt + 20'd1 : 20'd0;
      unique case (state)
        S_PA: if (qual) begin a <= sw_data; state <= S_RA; end
        S_PB: if (qual) begin b <= sw_data; state <= S_RB; end
        S_PC: if (qual) begin c <= sw_data; state <= S_RC; end
        S_PD: if (qual) begin d <= sw_data; state <= S_RD; end
        S_RA: if (qual) begin state <= S_PB; stage <= 3'd1; end
        S_RB: if (qual) begin state <= S_PC; stage <= 3'd2; end
        S_RC: if (qual) begin state <= S_PD; stage <= 3'd3; end
        S_RD: if (qual) begin
          state <= S_RUN;
          stage <= 3'd4;
          start <= 1'b1;
        end
        S_RUN: if (done) begin state <= S_FIN; stage <= 3'd5; end
        S_FIN: ;
        default: begin
          state <= S_PA;
          stage <= 3'd0;
          start <= 1'b0;
        end
      endcase
    end
  end
`endif

endmodule

// File: doc/operand_loader.md
# operand_loader

Upstream front end for the exam datapath. Captures four WIDTH-bit operands (a, b, c, d, in that order) from the debounced slide-switch bus, one per debounced press of a push-button, then raises `start` and holds it until the datapath reports `done`. Replaces ad-hoc entry logic in board wrappers. Provides a stage code for LED feedback.

## Interface
- `WIDTH`, 16, operand width.
- `HOLD_CYCLES`, 1000, consecutive samples needed to qualify a key press or release; legal range 1 to 2^20-1.

- `CLOCK_50`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `sw_data`  in  WIDTH  debounced switch value, sampled on capture.
- `key_n`  in  1  raw push-button, active-low (0 = pressed).
- `done`  in  1  datapath completion, level.
- `a`, `b`, `c`, `d`  out  WIDTH each  captured operands, registered.
- `start`  out  1  run request to datapath, registered level.
- `stage`  out  3  progress code, registered.
- `dut_rst_n`  out  1  datapath soft reset, active-low, registered.

## Operation
- The key filter is a 20-bit counter `kcnt`.
  - In press-wait states, `kcnt` increments each cycle `key_n`=0 and clears to 0 when `key_n`=1.
  - In release-wait states, `kcnt` increments each cycle `key_n`=1 and clears to 0 when `key_n`=0.
  - An event qualifies on the edge where `kcnt`==HOLD_CYCLES-1 and the key is still at the awaited level. `kcnt` clears to 0 on that edge.
- States and `stage` encoding:
  - `PRESS_A` 0, `PRESS_B` 1, `PRESS_C` 2, `PRESS_D` 3. Each press-wait state has a release-wait twin with the same `stage` value.
  - `RUN` 4, `FINISHED` 5. Values 6 and 7 are unused.
- Transitions:
  - `PRESS_x`: a qualified press captures `sw_data` into operand x. Go to `REL_x`.
  - `REL_x`: a qualified release goes to `PRESS_(next)`. `REL_D` goes to `RUN` instead.
  - `RUN`: `start`=1. When `done`=1 is sampled, go to `FINISHED`.
  - `FINISHED`: `start` stays 1. Key activity is ignored, unless `LOADER_RERUN_EN` is defined.
- Each operand is written exactly once per entry pass. It holds its value thereafter; there is no write in any other state.
- Only `key_n` low for HOLD_CYCLES cycles captures. A glitch shorter than that captures nothing and leaves the state unchanged.
- Unused state codes go to `PRESS_A` on the next edge. Operands are untouched; `start` is 0.

## Timing
- Reset values: `a`=`b`=`c`=`d`=0, `start`=0, `stage`=0, `dut_rst_n`=1, `kcnt`=0. State is `PRESS_A`.
- Reset takes effect immediately and asynchronously, at any point including mid-press or in `RUN`. The next pass restarts at `PRESS_A`.
- Capture latency: the operand updates on the edge of the HOLD_CYCLES-th consecutive low sample of `key_n`. `stage` is unchanged by a capture.
- `stage` increments on the edge of the qualifying release.
- `start` rises on the same edge as the release that qualifies `REL_D`.
- `done` is sampled from the cycle after `start` rises. If `done` is already 1 on entry to `RUN`, the move to `FINISHED` happens on the first `RUN` cycle.
- `done` dropping while in `FINISHED` has no effect.

## Configuration
- `LOADER_RERUN_EN` defined:
  - In `FINISHED`, a qualified press followed by a qualified release (same filter as entry) performs a rerun.
  - On the release edge: `start`←0, `dut_rst_n`←0 for exactly 2 cycles, then back to 1. Go to `PRESS_A`, `stage`=0.
  - Operands keep their old values until overwritten by the new pass.
- `LOADER_RERUN_EN` undefined:
  - `FINISHED` is terminal until `rst`.
  - `dut_rst_n` is constant 1.

## Test plan
All scenarios use HOLD_CYCLES=4 and WIDTH=16.
- Normal pass: enter 0x0003, 0x0002, 0x0005, 0x0000, each with 6-cycle press and 6-cycle release. Expect `a`=3, `b`=2, `c`=5, `d`=0, each updated on the 4th low cycle. `stage` steps 0→1→2→3→4. `start`=1 on `REL_D`'s 4th high cycle.
- Glitch rejection: 3-cycle low pulses on `key_n` in `PRESS_A` with `sw_data`=0xBEEF → `a` stays 0, `stage` stays 0. Then a 4-cycle low pulse → `a`=0xBEEF.
- Done handshake: after a pass, hold `done`=0 for 10 cycles → `stage`=4, `start`=1. Assert `done` → `stage`=5 next edge, `start` remains 1. Drop `done` → no change.
- Mid-operation reset: pull `rst` low in `REL_B` with `a`=0x1234 → all outputs return to reset values the same cycle. After release of `rst`, `stage`=0.
- Switch change after capture: after capturing `a`=0x00FF, change `sw_data` to 0xFFFF during `REL_A` → `a` remains 0x00FF.
- Rerun (macro defined): in `FINISHED`, press/release → `start`=0, `dut_rst_n` low exactly 2 cycles, `stage`=0. Operands are unchanged until the next capture. With the macro undefined, the same stimulus leaves `stage`=5 and `start`=1.
